// File: rtl/hid_axil_bridge.sv
// AXI4-Lite (64-bit) slave that turns uncached MMIO accesses into single-cycle
// hid_en/hid_we strobes for the peripheral SoC, one transaction at a time.
module hid_axil_bridge #(
    parameter int RD_LATENCY     = 1,
    parameter int AXI_ADDR_WIDTH = 32,
    parameter int HID_ADDR_WIDTH = 18
) (
    input  logic                      msoc_clk,
    input  logic                      rstn,

    input  logic [AXI_ADDR_WIDTH-1:0] s_awaddr,
    input  logic                      s_awvalid,
    output logic                      s_awready,
    input  logic [63:0]               s_wdata,
    input  logic [7:0]                s_wstrb,
    input  logic                      s_wvalid,
    output logic                      s_wready,
    output logic [1:0]                s_bresp,
    output logic                      s_bvalid,
    input  logic                      s_bready,

    input  logic [AXI_ADDR_WIDTH-1:0] s_araddr,
    input  logic                      s_arvalid,
    output logic                      s_arready,
    output logic [63:0]               s_rdata,
    output logic [1:0]                s_rresp,
    output logic                      s_rvalid,
    input  logic                      s_rready,

    output logic                      hid_en,
    output logic [7:0]                hid_we,
    output logic [HID_ADDR_WIDTH-1:0] hid_addr,
    output logic [63:0]               hid_wrdata,
    input  logic [63:0]               hid_rddata
);

    typedef enum logic [2:0] {
        IDLE,
        WR_ISSUE,
        WR_RESP,
        RD_ISSUE,
        RD_WAIT,
        RD_CAPTURE,
        RD_RESP
    } state_t;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [2:0] WAIT_INIT   = 3'((RD_LATENCY > 1) ? (RD_LATENCY - 2) : 0);

    state_t                    state;
    logic                      prio_wr;
    logic [2:0]                wait_cnt;
    logic                      wr_elig;
    logic                      rd_elig;
    logic                      grant_wr;
    logic                      grant_rd;
    logic                      aw_err;
    logic                      ar_err;
    logic [HID_ADDR_WIDTH-1:0] wr_hid_addr;
    logic [HID_ADDR_WIDTH-1:0] rd_hid_addr;

    // Handshake readies come straight from IDLE and the arbiter so an accept
    // costs no extra cycle; rstn gates them so nothing is accepted in reset.
    assign wr_elig   = s_awvalid && s_wvalid;
    assign rd_elig   = s_arvalid;
    assign grant_wr  = rstn && (state == IDLE) && wr_elig && (!rd_elig || prio_wr);
    assign grant_rd  = rstn && (state == IDLE) && rd_elig && (!wr_elig || !prio_wr);
    assign s_awready = grant_wr;
    assign s_wready  = grant_wr;
    assign s_arready = grant_rd;

    assign aw_err      = (s_awaddr >> HID_ADDR_WIDTH) != '0;
    assign ar_err      = (s_araddr >> HID_ADDR_WIDTH) != '0;
    assign wr_hid_addr = {s_awaddr[HID_ADDR_WIDTH-1:3], 3'b000};
    assign rd_hid_addr = {s_araddr[HID_ADDR_WIDTH-1:3], 3'b000};

    always_ff @(posedge msoc_clk or negedge rstn) begin
        if (!rstn) begin
            state      <= IDLE;
            prio_wr    <= 1'b1;
            wait_cnt   <= '0;
            hid_en     <= 1'b0;
            hid_we     <= '0;
            hid_addr   <= '0;
            hid_wrdata <= '0;
            s_bvalid   <= 1'b0;
            s_bresp    <= RESP_OKAY;
            s_rvalid   <= 1'b0;
            s_rresp    <= RESP_OKAY;
            s_rdata    <= '0;
        end else begin
            // Strobes are single-cycle; hid_addr/hid_wrdata hold their value.
            hid_en <= 1'b0;
            hid_we <= '0;
            case (state)
                IDLE: begin
                    if (grant_wr) begin
                        prio_wr <= 1'b0;
                        if (aw_err) begin
                            state    <= WR_RESP;
                            s_bvalid <= 1'b1;
                            s_bresp  <= RESP_SLVERR;
                        end else begin
                            state      <= WR_ISSUE;
                            hid_en     <= |s_wstrb;
                            hid_we     <= s_wstrb;
                            hid_addr   <= wr_hid_addr;
                            hid_wrdata <= s_wdata;
                        end
                    end else if (grant_rd) begin
                        prio_wr <= 1'b1;
                        if (ar_err) begin
                            state    <= RD_RESP;
                            s_rvalid <= 1'b1;
                            s_rresp  <= RESP_SLVERR;
                            s_rdata  <= '0;
                        end else begin
                            state    <= RD_ISSUE;
                            hid_en   <= 1'b1;
                            hid_addr <= rd_hid_addr;
                        end
                    end
                end
                WR_ISSUE: begin
                    state    <= WR_RESP;
                    s_bvalid <= 1'b1;
                    s_bresp  <= RESP_OKAY;
                end
                WR_RESP: begin
                    if (s_bready) begin
                        state    <= IDLE;
                        s_bvalid <= 1'b0;
                    end
                end
                RD_ISSUE: begin
                    if (RD_LATENCY > 1) begin
                        state    <= RD_WAIT;
                        wait_cnt <= WAIT_INIT;
                    end else begin
                        state <= RD_CAPTURE;
                    end
                end
                RD_WAIT: begin
                    if (wait_cnt == 3'd0) begin
                        state <= RD_CAPTURE;
                    end else begin
                        wait_cnt <= wait_cnt - 3'd1;
                    end
                end
                RD_CAPTURE: begin
                    state    <= RD_RESP;
                    s_rdata  <= hid_rddata;
                    s_rresp  <= RESP_OKAY;
                    s_rvalid <= 1'b1;
                end
                RD_RESP: begin
                    if (s_rready) begin
                        state    <= IDLE;
                        s_rvalid <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_hid_axil_bridge.sv
// Randomized bench for hid_axil_bridge: AXI-Lite master driver, latency-accurate
// peripheral model and a word-level memory reference model.
module tb_hid_axil_bridge;

    localparam int RL = 3;
    localparam int AW = 32;
    localparam int HW = 18;

    logic          msoc_clk = 1'b0;
    logic          rstn;
    logic [AW-1:0] s_awaddr;
    logic          s_awvalid;
    logic          s_awready;
    logic [63:0]   s_wdata;
    logic [7:0]    s_wstrb;
    logic          s_wvalid;
    logic          s_wready;
    logic [1:0]    s_bresp;
    logic          s_bvalid;
    logic          s_bready;
    logic [AW-1:0] s_araddr;
    logic          s_arvalid;
    logic          s_arready;
    logic [63:0]   s_rdata;
    logic [1:0]    s_rresp;
    logic          s_rvalid;
    logic          s_rready;
    logic          hid_en;
    logic [7:0]    hid_we;
    logic [HW-1:0] hid_addr;
    logic [63:0]   hid_wrdata;
    logic [63:0]   hid_rddata;

    int checks   = 0;
    int failures = 0;
    bit prio_wr;
    int force_hold = -1;

    typedef struct packed {
        logic [17:0] addr;
        logic [7:0]  we;
        logic [63:0] data;
    } wr_exp_t;

    wr_exp_t     exp_wq[$];
    logic [17:0] exp_rq[$];
    logic [63:0] ref_mem [logic [14:0]];
    logic [63:0] per_mem [logic [14:0]];
    logic [63:0] pd [RL];
    logic [17:0] pa [RL];
    bit          pv [RL];

    hid_axil_bridge #(
        .RD_LATENCY    (RL),
        .AXI_ADDR_WIDTH(AW),
        .HID_ADDR_WIDTH(HW)
    ) dut (
        .msoc_clk  (msoc_clk),
        .rstn      (rstn),
        .s_awaddr  (s_awaddr),
        .s_awvalid (s_awvalid),
        .s_awready (s_awready),
        .s_wdata   (s_wdata),
        .s_wstrb   (s_wstrb),
        .s_wvalid  (s_wvalid),
        .s_wready  (s_wready),
        .s_bresp   (s_bresp),
        .s_bvalid  (s_bvalid),
        .s_bready  (s_bready),
        .s_araddr  (s_araddr),
        .s_arvalid (s_arvalid),
        .s_arready (s_arready),
        .s_rdata   (s_rdata),
        .s_rresp   (s_rresp),
        .s_rvalid  (s_rvalid),
        .s_rready  (s_rready),
        .hid_en    (hid_en),
        .hid_we    (hid_we),
        .hid_addr  (hid_addr),
        .hid_wrdata(hid_wrdata),
        .hid_rddata(hid_rddata)
    );

    always #5 msoc_clk = ~msoc_clk;

    assign hid_rddata = pd[RL-1];

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%0h exp=0x%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [63:0] init_val(input logic [14:0] idx);
        return {17'h0, idx, 32'hC0DE_0000} ^ 64'hA5A5_5A5A_0F0F_F0F0;
    endfunction

    function automatic logic [63:0] merge(input logic [63:0] old, input logic [63:0] d,
                                          input logic [7:0] s);
        logic [63:0] r;
        r = old;
        for (int b = 0; b < 8; b++) if (s[b]) r[8*b +: 8] = d[8*b +: 8];
        return r;
    endfunction

    function automatic logic [63:0] rd_ref(input logic [14:0] idx);
        return ref_mem.exists(idx) ? ref_mem[idx] : init_val(idx);
    endfunction

    function automatic logic [63:0] rd_per(input logic [14:0] idx);
        return per_mem.exists(idx) ? per_mem[idx] : init_val(idx);
    endfunction

    function automatic logic [31:0] rand_addr();
        logic [31:0] a;
        if ($urandom_range(0, 7) == 0) begin
            a     = $urandom;
            a[31] = 1'b1;
        end else begin
            a = 32'h0001_0000 | {24'h0, 5'($urandom_range(0, 31)), 3'($urandom_range(0, 7))};
        end
        return a;
    endfunction

    // Peripheral: writes land at the strobe edge, read data appears RL-1 edges later.
    always @(posedge msoc_clk or negedge rstn) begin
        if (!rstn) begin
            for (int k = 0; k < RL; k++) begin
                pv[k] <= 1'b0;
                pd[k] <= '0;
                pa[k] <= '0;
            end
        end else begin
            if (hid_en && hid_we != 8'h00)
                per_mem[hid_addr[17:3]] = merge(rd_per(hid_addr[17:3]), hid_wrdata, hid_we);
            pd[0] <= (hid_en && hid_we == 8'h00) ? rd_per(hid_addr[17:3]) : {$urandom, $urandom};
            pa[0] <= hid_addr;
            pv[0] <= hid_en && hid_we == 8'h00;
            for (int k = 1; k < RL; k++) begin
                pd[k] <= pd[k-1];
                pa[k] <= pa[k-1];
                pv[k] <= pv[k-1];
            end
        end
    end

    always @(negedge msoc_clk) begin
        if (rstn) begin
            if (hid_en) begin
                if (hid_we != 8'h00) begin
                    if (exp_wq.size() == 0) begin
                        chk("unexp_hid_wr", 64'(hid_en), 64'd0);
                    end else begin
                        wr_exp_t e;
                        e = exp_wq.pop_front();
                        chk("hid_wr_addr", 64'(hid_addr), 64'(e.addr));
                        chk("hid_wr_we", 64'(hid_we), 64'(e.we));
                        chk("hid_wr_data", hid_wrdata, e.data);
                    end
                end else begin
                    if (exp_rq.size() == 0) begin
                        chk("unexp_hid_rd", 64'(hid_en), 64'd0);
                    end else begin
                        logic [17:0] a;
                        a = exp_rq.pop_front();
                        chk("hid_rd_addr", 64'(hid_addr), 64'(a));
                    end
                end
            end else if (hid_we != 8'h00) begin
                chk("we_without_en", 64'(hid_we), 64'd0);
            end
            for (int k = 0; k < RL; k++)
                if (pv[k]) chk("hid_addr_hold", 64'(hid_addr), 64'(pa[k]));
        end
    end

    task automatic step();
        @(posedge msoc_clk);
        #1;
    endtask

    task automatic chk_no_accept(input string tag);
        chk(tag, 64'({s_awready, s_wready, s_arready}), 64'd0);
    endtask

    task automatic pick_hold(output int hold);
        if (force_hold >= 0) hold = force_hold;
        else if ($urandom_range(0, 1) == 1) hold = -1;
        else hold = $urandom_range(0, 6);
    endtask

    // Called one cycle after the write was accepted.
    task automatic write_txn(input logic [31:0] a, input logic [63:0] d, input logic [7:0] s);
        bit         err;
        int         lat;
        int         hold;
        logic [1:0] eresp;
        err   = (a[31:18] != 14'h0);
        eresp = err ? 2'b10 : 2'b00;
        if (!err) begin
            if (s != 8'h00) exp_wq.push_back({a[17:3], 3'b000, s, d});
            ref_mem[a[17:3]] = merge(rd_ref(a[17:3]), d, s);
        end
        pick_hold(hold);
        s_bready = (hold < 0);
        lat = 1;
        @(negedge msoc_clk);
        while (!s_bvalid && lat < 16) begin
            chk_no_accept("no_accept_wr");
            @(negedge msoc_clk);
            lat++;
        end
        if (!s_bvalid) begin
            chk("b_timeout", 64'(s_bvalid), 64'd1);
            s_bready = 1'b0;
            return;
        end
        chk("b_latency", 64'(lat), err ? 64'd1 : 64'd2);
        chk("bresp", 64'(s_bresp), 64'(eresp));
        for (int i = 0; i < hold; i++) begin
            step();
            @(negedge msoc_clk);
            chk("b_hold_valid", 64'(s_bvalid), 64'd1);
            chk("b_hold_resp", 64'(s_bresp), 64'(eresp));
            chk_no_accept("no_accept_b");
        end
        if (hold >= 0) begin
            step();
            s_bready = 1'b1;
        end
        step();
        s_bready = 1'b0;
    endtask

    task automatic read_txn(input logic [31:0] a);
        bit          err;
        int          lat;
        int          hold;
        logic [63:0] edata;
        logic [1:0]  eresp;
        err   = (a[31:18] != 14'h0);
        eresp = err ? 2'b10 : 2'b00;
        edata = err ? 64'd0 : rd_ref(a[17:3]);
        if (!err) exp_rq.push_back({a[17:3], 3'b000});
        pick_hold(hold);
        s_rready = (hold < 0);
        lat = 1;
        @(negedge msoc_clk);
        while (!s_rvalid && lat < 16) begin
            chk_no_accept("no_accept_rd");
            @(negedge msoc_clk);
            lat++;
        end
        if (!s_rvalid) begin
            chk("r_timeout", 64'(s_rvalid), 64'd1);
            s_rready = 1'b0;
            return;
        end
        chk("r_latency", 64'(lat), err ? 64'd1 : 64'(2 + RL));
        chk("rresp", 64'(s_rresp), 64'(eresp));
        chk("rdata", s_rdata, edata);
        for (int i = 0; i < hold; i++) begin
            step();
            @(negedge msoc_clk);
            chk("r_hold_valid", 64'(s_rvalid), 64'd1);
            chk("r_hold_data", s_rdata, edata);
            chk_no_accept("no_accept_r");
        end
        if (hold >= 0) begin
            step();
            s_rready = 1'b1;
        end
        step();
        s_rready = 1'b0;
    endtask

    // Present a write and/or a read together; the reference arbiter predicts the order.
    task automatic run_round(input bit do_w, input logic [31:0] wa, input logic [63:0] wd,
                             input logic [7:0] ws, input bit do_r, input logic [31:0] ra);
        bit pend_w;
        bit pend_r;
        bit exp_wr;
        bit got_wr;
        int idle;
        pend_w = do_w;
        pend_r = do_r;
        if (do_w) begin
            s_awaddr  = wa;
            s_wdata   = wd;
            s_wstrb   = ws;
            s_awvalid = 1'b1;
            s_wvalid  = 1'b1;
        end
        if (do_r) begin
            s_araddr  = ra;
            s_arvalid = 1'b1;
        end
        idle = 0;
        while (pend_w || pend_r) begin
            @(negedge msoc_clk);
            if (s_awready || s_wready || s_arready) begin
                exp_wr = pend_w && (!pend_r || prio_wr);
                got_wr = s_awready;
                chk("grant_aw", 64'(s_awready), 64'(exp_wr));
                chk("grant_w", 64'(s_wready), 64'(exp_wr));
                chk("grant_ar", 64'(s_arready), 64'(!exp_wr));
                prio_wr = !exp_wr;
                step();
                if (got_wr) begin
                    s_awvalid = 1'b0;
                    s_wvalid  = 1'b0;
                    pend_w    = 1'b0;
                    write_txn(wa, wd, ws);
                end else begin
                    s_arvalid = 1'b0;
                    pend_r    = 1'b0;
                    read_txn(ra);
                end
                idle = 0;
            end else begin
                idle++;
                if (idle > 20) begin
                    chk("grant_timeout", 64'(s_awready || s_arready), 64'd1);
                    pend_w    = 1'b0;
                    pend_r    = 1'b0;
                    s_awvalid = 1'b0;
                    s_wvalid  = 1'b0;
                    s_arvalid = 1'b0;
                end
                step();
            end
        end
    endtask

    initial begin
        int  kind;
        int  wait_ar;
        rstn      = 1'b0;
        s_awaddr  = 32'h0000_6000;
        s_wdata   = 64'h41;
        s_wstrb   = 8'hFF;
        s_awvalid = 1'b1;
        s_wvalid  = 1'b1;
        s_araddr  = 32'h0001_0010;
        s_arvalid = 1'b1;
        s_bready  = 1'b0;
        s_rready  = 1'b0;
        prio_wr   = 1'b1;
        ref_mem[15'h2002] = 64'h0123_4567_89AB_CDEF;
        per_mem[15'h2002] = 64'h0123_4567_89AB_CDEF;

        repeat (3) @(negedge msoc_clk);
        chk("rst_ready", 64'({s_awready, s_wready, s_arready}), 64'd0);
        chk("rst_valid", 64'({s_bvalid, s_rvalid}), 64'd0);
        chk("rst_hid_en", 64'(hid_en), 64'd0);
        chk("rst_hid_we", 64'(hid_we), 64'd0);
        chk("rst_hid_addr", 64'(hid_addr), 64'd0);
        chk("rst_hid_wrdata", hid_wrdata, 64'd0);
        chk("rst_rdata", s_rdata, 64'd0);
        chk("rst_resp", 64'({s_bresp, s_rresp}), 64'd0);

        step();
        rstn = 1'b1;
        // Both channels valid out of reset: expect W, R, W, R.
        run_round(1'b1, 32'h0000_6000, 64'h41, 8'hFF, 1'b1, 32'h0001_0010);
        run_round(1'b1, 32'h0001_0078, 64'hDEAD_BEEF_CAFE_F00D, 8'h0F, 1'b1, 32'h0000_6000);
        run_round(1'b0, 32'h0, 64'h0, 8'h00, 1'b1, 32'h0001_0078);

        force_hold = 10;
        run_round(1'b1, 32'h0004_0000, 64'h1234, 8'hFF, 1'b1, 32'h0004_0000);
        run_round(1'b1, 32'h0001_0080, 64'h5555_AAAA_5555_AAAA, 8'h00, 1'b1, 32'h0001_0080);
        force_hold = -1;

        for (int n = 0; n < 60; n++) begin
            kind = $urandom_range(0, 2);
            run_round(kind != 1, rand_addr(), {$urandom, $urandom}, 8'($urandom),
                      kind != 0, rand_addr());
        end

        // Reset in the middle of a read's wait window.
        s_araddr  = 32'h0001_0100;
        s_arvalid = 1'b1;
        wait_ar   = 0;
        @(negedge msoc_clk);
        while (!s_arready && wait_ar < 10) begin
            @(negedge msoc_clk);
            wait_ar++;
        end
        chk("mid_rst_accept", 64'(s_arready), 64'd1);
        prio_wr = 1'b1;
        step();
        s_arvalid = 1'b0;
        exp_rq.push_back(18'h10100);
        step();
        s_arvalid = 1'b1;
        #2;
        rstn = 1'b0;
        #1;
        chk("mid_rst_rvalid", 64'(s_rvalid), 64'd0);
        chk("mid_rst_rdata", s_rdata, 64'd0);
        chk("mid_rst_hid_en", 64'(hid_en), 64'd0);
        chk("mid_rst_hid_addr", 64'(hid_addr), 64'd0);
        chk("mid_rst_arready", 64'(s_arready), 64'd0);
        s_arvalid = 1'b0;
        s_rready  = 1'b1;
        repeat (3) step();
        rstn = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(negedge msoc_clk);
            chk("post_rst_no_r", 64'(s_rvalid), 64'd0);
        end
        s_rready = 1'b0;
        step();
        exp_rq.delete();
        prio_wr = 1'b1;
        run_round(1'b1, 32'h0001_0100, 64'h0F0F_0F0F_0F0F_0F0F, 8'hF0, 1'b1, 32'h0001_0100);

        repeat (2) @(negedge msoc_clk);
        chk("exp_q_empty", 64'(exp_wq.size() + exp_rq.size()), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout got=running exp=finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/hid_axil_bridge.md
Name: hid_axil_bridge

Overview:
- AXI4-Lite slave (64-bit data) that converts CPU uncached MMIO transactions into the single-cycle hid_en/hid_we/hid_addr/hid_wrdata/hid_rddata bus consumed by the peripheral SoC.
- Sits directly upstream of the peripheral subsystem (UART, SD, keyboard, framebuffer, Ethernet, boot RAM).
- Handles one transaction at a time.
- Holds the hid address stable for the read latency and arbitrates fairly between the read and write channels.

Parameters:
RD_LATENCY, 1, cycles from the hid_en cycle to the edge that samples hid_rddata (legal 1..7)
AXI_ADDR_WIDTH, 32, width of s_awaddr/s_araddr
HID_ADDR_WIDTH, 18, width of hid_addr (byte address)

Ports:
msoc_clk  in  1  clock
rstn  in  1  asynchronous, active-low reset
s_awaddr  in  AXI_ADDR_WIDTH  write address (byte)
s_awvalid / s_awready  in/out  1  AW handshake
s_wdata  in  64  write data
s_wstrb  in  8  byte strobes
s_wvalid / s_wready  in/out  1  W handshake
s_bresp  out  2  write response
s_bvalid / s_bready  out/in  1  B handshake
s_araddr  in  AXI_ADDR_WIDTH  read address (byte)
s_arvalid / s_arready  in/out  1  AR handshake
s_rdata  out  64  read data
s_rresp  out  2  read response
s_rvalid / s_rready  out/in  1  R handshake
hid_en  out  1  access strobe, one cycle per transaction
hid_we  out  8  byte write enables (0 = read)
hid_addr  out  HID_ADDR_WIDTH  byte address, bits [2:0] forced 0
hid_wrdata  out  64  write data
hid_rddata  in  64  read data from peripheral mux

Behaviour:
- Reset (async, rstn low): state IDLE, all ready/valid outputs 0, hid_en 0, hid_we 0, hid_addr 0, hid_wrdata 0, s_rdata 0, resp 0, priority flag = write. Reset mid-transaction drops the transaction; no B/R is issued for it.
- States:
  - IDLE: wait for a request.
  - WR_ISSUE: one cycle.
  - WR_RESP: wait for s_bready.
  - RD_ISSUE: one cycle.
  - RD_WAIT: RD_LATENCY-1 cycles; skipped when RD_LATENCY=1.
  - RD_CAPTURE: sample hid_rddata.
  - RD_RESP: wait for s_rready.
- IDLE: a write is eligible only when s_awvalid and s_wvalid are both 1. If both a write and a read are eligible, grant the side opposite the last granted one (round-robin); otherwise grant whichever is eligible.
- Write accept: s_awready and s_wready are high together for one cycle only when the write is granted. AW and W are never accepted separately. Address, data and strobes are latched.
- Read accept: s_arready is high for one cycle when the read is granted; the address is latched.
- Address check: latched addr[AXI_ADDR_WIDTH-1:HID_ADDR_WIDTH] != 0 is an error.
  - Error write: no hid_en pulse; go to WR_RESP with bresp=2'b10 (SLVERR).
  - Error read: no hid_en pulse; go to RD_RESP with rdata=0, rresp=SLVERR.
- WR_ISSUE: hid_en=1, hid_we=wstrb, hid_addr={addr[17:3],3'b000}, hid_wrdata=wdata, all registered outputs for exactly one cycle. wstrb==0 suppresses hid_en; the response is still OKAY. Next state WR_RESP.
- WR_RESP: s_bvalid=1, bresp=OKAY, held until s_bready; then IDLE.
- RD_ISSUE: hid_en=1, hid_we=0 for one cycle.
- hid_addr is held unchanged from RD_ISSUE through the RD_CAPTURE sampling edge.
- hid_rddata is sampled into s_rdata on the edge RD_LATENCY cycles after the hid_en cycle. Then RD_RESP: s_rvalid=1, rresp=OKAY, s_rdata stable until s_rready; then IDLE.
- Outside WR_ISSUE/RD_ISSUE: hid_en=0, hid_we=0. hid_addr and hid_wrdata keep their last values (no glitching).
- No new AR/AW is accepted while any transaction is outstanding. B/R valid never drops before its handshake.
- Throughput with ready held high:
  - Write: 3 cycles per transaction (accept, issue, response).
  - Read: 3+RD_LATENCY cycles per transaction.
- Both hid_en and hid_we != 0 in the same cycle occurs only in WR_ISSUE. Downstream pop side-effects (UART RX, keyboard FIFO) are triggered only by writes, so reads are side-effect free.

Test Plan:
- Write 0x0000_0000_0000_0041, wstrb=0xFF, to addr 0x0000_6000 (UART TX). Expect exactly one hid_en cycle with hid_we=0xFF, hid_addr=0x06000, hid_wrdata=0x41, then bvalid with bresp=0.
- RD_LATENCY=1 and 3: read 0x0001_0010, with the model returning 0x0123_4567_89AB_CDEF one cycle after address. Expect rdata equal to the model value, hid_addr constant across the wait, rresp=0.
- AW, W and AR all valid at reset, held for 4 transactions. Grants alternate W,R,W,R; no overlap of hid_en between transactions.
- Addr 0x0004_0000 write and read. Expect no hid_en; bresp=2 and rresp=2 with rdata=0.
- Hold s_bready/s_rready low for 10 cycles. Expect valid and data stable, no new AR/AW accepted. Deassert rstn mid-RD_WAIT: all outputs return to reset values immediately and no R is issued.
- wstrb=0x0F to addr 0x0001_0078 (LED register). Expect hid_we=0x0F. wstrb=0: no hid_en, bresp=0.
